// File: rtl/intersection_ctrl.sv
// ============================================================================
//  Module   : intersection_ctrl
//  Purpose  : Main/side road traffic-light controller, Moore FSM on a tick
//             time base. Macro INTERSECTION_CTRL_PED_EN adds a pedestrian phase.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module intersection_ctrl #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5,
    parameter int TW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_pending
);

    localparam logic [2:0] c_MG   = 3'd0;
    localparam logic [2:0] c_MY   = 3'd1;
    localparam logic [2:0] c_AR1  = 3'd2;
    localparam logic [2:0] c_SG   = 3'd3;
    localparam logic [2:0] c_SY   = 3'd4;
    localparam logic [2:0] c_AR2  = 3'd5;
    localparam logic [2:0] c_WALK = 3'd6;

    localparam logic [TW-1:0] c_GMIN_M1 = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] c_GMAX_M1 = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] c_YEL_M1  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] c_AR_M1   = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] c_WALK_M1 = TW'(WALK_T - 1);

`ifdef INTERSECTION_CTRL_PED_EN
    localparam logic c_PED_EN = 1'b1;
`else
    localparam logic c_PED_EN = 1'b0;
`endif

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [TW-1:0] r_timer;
    logic          r_side_lat;
    logic          r_ped_pending;
    logic          w_change;

    assign w_change = (w_next != r_state);

    // State, timer and side-road latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_MG;
            r_timer    <= '0;
            r_side_lat <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_change)
                r_timer <= '0;
            else if (tick && (r_timer != '1))
                r_timer <= r_timer + 1'b1;
            if ((w_next == c_SG) && (r_state != c_SG))
                r_side_lat <= 1'b0;
            else if (side_req && (r_state != c_SG))
                r_side_lat <= 1'b1;
        end
    end

`ifdef INTERSECTION_CTRL_PED_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_ped_pending <= 1'b0;
        else if ((w_next == c_WALK) && (r_state != c_WALK))
            r_ped_pending <= 1'b0;
        else if (ped_req && (r_state != c_WALK))
            r_ped_pending <= 1'b1;
    end
`else
    logic w_unused_ped;
    assign w_unused_ped  = ped_req;
    assign r_ped_pending = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_MG:   if (tick && (r_timer >= c_GMIN_M1) && (r_side_lat || r_ped_pending))
                        w_next = c_MY;
            c_MY:   if (tick && (r_timer == c_YEL_M1))
                        w_next = c_AR1;
            c_AR1:  if (tick && (r_timer == c_AR_M1))
                        w_next = (c_PED_EN && r_ped_pending) ? c_WALK : c_SG;
            // Side green ends at its cap, or early once the minimum is met and the road is clear
            c_SG:   if (tick && ((r_timer == c_GMAX_M1) || ((r_timer >= c_GMIN_M1) && !side_req)))
                        w_next = c_SY;
            c_SY:   if (tick && (r_timer == c_YEL_M1))
                        w_next = c_AR2;
            c_AR2:  if (tick && (r_timer == c_AR_M1))
                        w_next = c_MG;
            c_WALK: if (tick && (r_timer == c_WALK_M1))
                        w_next = r_side_lat ? c_SG : c_MG;
            default: w_next = c_MG;
        endcase
    end

    always_comb begin
        main_r = 1'b0;
        main_y = 1'b0;
        main_g = 1'b0;
        side_r = 1'b0;
        side_y = 1'b0;
        side_g = 1'b0;
        walk   = 1'b0;
        case (r_state)
            c_MG:   begin main_g = 1'b1; side_r = 1'b1; end
            c_MY:   begin main_y = 1'b1; side_r = 1'b1; end
            c_SG:   begin main_r = 1'b1; side_g = 1'b1; end
            c_SY:   begin main_r = 1'b1; side_y = 1'b1; end
            c_WALK: begin main_r = 1'b1; side_r = 1'b1; walk = c_PED_EN; end
            default: begin main_r = 1'b1; side_r = 1'b1; end
        endcase
    end

    assign phase       = r_state;
    assign ped_pending = r_ped_pending;

endmodule

`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
// ============================================================================
//  Module   : tb_intersection_ctrl
//  Purpose  : Scoreboard bench for intersection_ctrl (reference model + phase
//             duration checks).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intersection_ctrl;

    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YEL  = 2;
    localparam int AR   = 1;
    localparam int WLK  = 3;
`ifdef INTERSECTION_CTRL_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, tick, side_req, ped_req;
    logic       main_r, main_y, main_g, side_r, side_y, side_g, walk, ped_pending;
    logic [2:0] phase;

    intersection_ctrl #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL),
        .ALLRED_T(AR), .WALK_T(WLK), .TW(8)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .side_req(side_req), .ped_req(ped_req),
        .main_r(main_r), .main_y(main_y), .main_g(main_g),
        .side_r(side_r), .side_y(side_y), .side_g(side_g),
        .walk(walk), .phase(phase), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [6:0] lamps;
        logic       ped;
        logic [7:0] timer;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int m_state = 0, m_cnt = 0;
    bit m_side = 0, m_ped = 0;

    int phase_cnt[8];
    int last_run[8];
    int prev_ph, run_len, walk_next;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // {main_r,main_y,main_g,side_r,side_y,side_g,walk} for each phase
    function automatic logic [6:0] lamp_of(input int p);
        case (p)
            0: return 7'b001_100_0;
            1: return 7'b010_100_0;
            3: return 7'b100_001_0;
            4: return 7'b100_010_0;
            6: return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic model_push();
        int ns, nc;
        bit ns_side, ns_ped;
        exp_t e;
        if (rst) begin
            ns = 0; nc = 0; ns_side = 0; ns_ped = 0;
        end else begin
            ns = m_state;
            if (tick) begin
                case (m_state)
                    0: if (m_cnt + 1 >= GMIN && (m_side || m_ped)) ns = 1;
                    1: if (m_cnt + 1 == YEL) ns = 2;
                    2: if (m_cnt + 1 == AR) ns = (PED && m_ped) ? 6 : 3;
                    3: if (m_cnt + 1 == GMAX || (m_cnt + 1 >= GMIN && !side_req)) ns = 4;
                    4: if (m_cnt + 1 == YEL) ns = 5;
                    5: if (m_cnt + 1 == AR) ns = 0;
                    6: if (m_cnt + 1 == WLK) ns = m_side ? 3 : 0;
                    default: ns = 0;
                endcase
            end
            if (ns != m_state) nc = 0;
            else nc = (tick && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            if (ns == 3 && m_state != 3) ns_side = 0;
            else ns_side = m_side | (side_req && m_state != 3);
            if (!PED) ns_ped = 0;
            else if (ns == 6 && m_state != 6) ns_ped = 0;
            else ns_ped = m_ped | (ped_req && m_state != 6);
        end
        m_state = ns; m_cnt = nc; m_side = ns_side; m_ped = ns_ped;
        e.ph = 3'(ns); e.lamps = lamp_of(ns); e.ped = ns_ped; e.timer = 8'(nc);
        exp_q.push_back(e);
    endtask

    task automatic track_init();
        for (int i = 0; i < 8; i++) begin
            phase_cnt[i] = 0;
            last_run[i]  = 0;
        end
        prev_ph   = int'(phase);
        run_len   = 1;
        walk_next = -1;
    endtask

    task automatic step();
        exp_t e;
        int   p;
        model_push();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("phase", int'(phase), int'(e.ph));
        check_eq("lamps", int'({main_r, main_y, main_g, side_r, side_y, side_g, walk}), int'(e.lamps));
        check_eq("ped_pending", int'(ped_pending), int'(e.ped));
        check_eq("timer", int'(dut.r_timer), int'(e.timer));
        p = int'(phase);
        phase_cnt[p]++;
        if (p == prev_ph) run_len++;
        else begin
            last_run[prev_ph] = run_len;
            if (prev_ph == 6) walk_next = p;
            prev_ph = p;
            run_len = 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        track_init();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; tick = 1'b1; side_req = 1'b0; ped_req = 1'b0;

        do_reset();
        check_eq("rst_phase", int'(phase), 0);
        check_eq("rst_main_g", int'(main_g), 1);
        check_eq("rst_side_r", int'(side_r), 1);
        check_eq("rst_walk", int'(walk), 0);

        // Idle: main green holds with no demand
        repeat (30) step();
        check_eq("idle_mg_cycles", phase_cnt[0], 30);

        // Single side pulse
        do_reset();
        step();
        side_req = 1'b1; step(); side_req = 1'b0;
        repeat (18) step();
        check_eq("pulse_mg_len", last_run[0], 4);
        check_eq("pulse_my_len", last_run[1], 2);
        check_eq("pulse_ar1_len", last_run[2], 1);
        check_eq("pulse_sg_len", last_run[3], 4);
        check_eq("pulse_sy_len", last_run[4], 2);
        check_eq("pulse_ar2_len", last_run[5], 1);

        // Side held high: side green capped, second cycle after min green
        do_reset();
        side_req = 1'b1;
        repeat (26) step();
        side_req = 1'b0;
        check_eq("held_sg_len", last_run[3], 8);
        check_eq("held_sy_len", last_run[4], 2);
        check_eq("held_mg2_len", last_run[0], 4);
        check_eq("held_sg_cycles", phase_cnt[3], 10);

        // Pedestrian pulse only
        do_reset();
        step();
        ped_req = 1'b1; step(); ped_req = 1'b0;
        repeat (14) step();
        if (PED) begin
            check_eq("ped_walk_len", last_run[6], 3);
            check_eq("ped_walk_next", walk_next, 0);
            check_eq("ped_no_sg", phase_cnt[3], 0);
        end else begin
            check_eq("noped_mg_hold", phase_cnt[0], 16);
        end

        // Pedestrian and side together
        do_reset();
        step();
        ped_req = 1'b1; side_req = 1'b1; step(); ped_req = 1'b0; side_req = 1'b0;
        repeat (16) step();
        if (PED) begin
            check_eq("both_walk_len", last_run[6], 3);
            check_eq("both_walk_next", walk_next, 3);
        end else begin
            check_eq("both_no_walk", phase_cnt[6], 0);
        end
        check_eq("both_sg_len", last_run[3], 4);

        // Reset in the middle of side green
        do_reset();
        side_req = 1'b1; step(); side_req = 1'b0;
        for (int i = 0; i < 40 && phase != 3'd3; i++) step();
        check_eq("sg_reached", int'(phase), 3);
        step(); step();
        check_eq("sg_timer2", int'(dut.r_timer), 2);
        rst = 1'b1; side_req = 1'b1; ped_req = 1'b1;
        step();
        rst = 1'b0; side_req = 1'b0; ped_req = 1'b0;
        track_init();
        check_eq("midrst_phase", int'(phase), 0);
        check_eq("midrst_main_g", int'(main_g), 1);
        check_eq("midrst_timer", int'(dut.r_timer), 0);
        check_eq("midrst_ped", int'(ped_pending), 0);
        repeat (10) step();
        check_eq("midrst_latch_clear", phase_cnt[0], 10);

        // tick low: requests latch, nothing advances
        tick = 1'b0; side_req = 1'b1; ped_req = 1'b1;
        step();
        side_req = 1'b0; ped_req = 1'b0;
        track_init();
        repeat (9) step();
        check_eq("notick_phase_hold", phase_cnt[0], 9);
        check_eq("notick_timer_hold", int'(dut.r_timer), 10);
        if (PED) check_eq("notick_ped_latched", int'(ped_pending), 1);
        tick = 1'b1;
        step();
        check_eq("resume_phase", int'(phase), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 The module SHALL have parameter GREEN_MIN, default 4: minimum green duration, in ticks, for either road.
REQ-002 The module SHALL have parameter GREEN_MAX, default 10: maximum side-road green duration, in ticks.
REQ-003 The module SHALL have parameter YELLOW_T, default 3: yellow duration, in ticks.
REQ-004 The module SHALL have parameter ALLRED_T, default 1: all-red clearance duration, in ticks.
REQ-005 The module SHALL have parameter WALK_T, default 5: pedestrian walk duration, in ticks.
REQ-006 The module SHALL have parameter TW, default 8: timer width; every duration parameter lies in 1..2^TW-1, and GREEN_MIN <= GREEN_MAX.
REQ-007 The module SHALL have: clk  in  1  sole clock; all logic on its rising edge.
REQ-008 The module SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-009 The module SHALL have: tick  in  1  single-cycle time-base enable.
REQ-010 The module SHALL have: side_req  in  1  side-road vehicle sensor, level.
REQ-011 The module SHALL have: ped_req  in  1  pedestrian button, pulse or level.
REQ-012 The module SHALL have: main_r, main_y, main_g  out  1 each  main-road lamps.
REQ-013 The module SHALL have: side_r, side_y, side_g  out  1 each  side-road lamps.
REQ-014 The module SHALL have: walk  out  1  pedestrian walk lamp.
REQ-015 The module SHALL have: phase  out  3  current state code.
REQ-016 The module SHALL have: ped_pending  out  1  latched pedestrian request.

Function
REQ-017 The controller SHALL be a Moore FSM with these states and phase codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, WALK=6.
REQ-018 All outputs SHALL be decoded from registered state and latches only.
REQ-019 Lamps SHALL be: MG main_g/side_r; MY main_y/side_r; SG main_r/side_g; SY main_r/side_y; AR1, AR2 and WALK both red; walk=1 only in WALK.
REQ-020 A TW-bit timer SHALL increment only on cycles with tick=1 and SHALL clear to 0 on every state change.
REQ-021 A timed state of duration N SHALL exit on the tick cycle where timer==N-1, so that it lasts exactly N ticks.
REQ-022 side_lat SHALL set when side_req=1 in any state other than SG, and SHALL clear on entry to SG; when set and clear coincide, clear wins.
REQ-023 MG SHALL go to MY on a tick cycle where timer>=GREEN_MIN-1 and demand exists (side_lat or ped_pending); with no demand, MG SHALL hold indefinitely and the timer SHALL saturate at 2^TW-1.
REQ-024 MY SHALL go to AR1 after YELLOW_T ticks.
REQ-025 AR1 SHALL go, after ALLRED_T ticks, to WALK if ped_pending, else to SG.
REQ-026 SG SHALL go to SY on a tick cycle where timer==GREEN_MAX-1, or where timer>=GREEN_MIN-1 and side_req=0.
REQ-027 SY SHALL go to AR2 after YELLOW_T ticks, and AR2 SHALL go to MG after ALLRED_T ticks.
REQ-028 WALK SHALL exit after WALK_T ticks, to SG if side_lat, else to MG.
REQ-029 Any illegal state code SHALL return to MG on the next edge.
REQ-030 With tick=0, no state change and no timer change SHALL occur; latches SHALL still capture requests.

Reset
REQ-031 With rst=1 at a clk edge, state SHALL become MG, timer 0, side_lat 0 and ped_pending 0.
REQ-032 After reset, outputs SHALL be main_g=1, side_r=1, all other lamps 0, walk=0, phase=0.
REQ-033 Reset SHALL override all other inputs and SHALL take effect from any state, mid-phase included.

Configuration
REQ-034 Macro INTERSECTION_CTRL_PED_EN SHALL control the pedestrian feature.
REQ-035 When INTERSECTION_CTRL_PED_EN is defined: ped_pending SHALL set on ped_req=1 in any state except WALK, clear on WALK entry (clear wins), and count as MG demand.
REQ-036 When INTERSECTION_CTRL_PED_EN is undefined: ped_req SHALL be ignored, ped_pending and walk SHALL be tied to 0, WALK SHALL be unreachable, and AR1 SHALL always go to SG.

Verification
Parameters for all scenarios: GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, WALK_T=3, tick=1 every cycle.
REQ-037 No requests for 30 cycles after reset -> phase stays 0, main_g=1, side_r=1 throughout.
REQ-038 1-cycle side_req pulse at cycle 1 -> MG 4, MY 2, AR1 1, SG 4 cycles (side_req low), then SY 2, AR2 1, MG.
REQ-039 side_req held high -> SG lasts exactly 8 cycles, then SY; side_lat re-sets during SY and a second cycle follows after MG's minimum.
REQ-040 PED_EN, ped_req pulse only -> MG, MY, AR1, then WALK for 3 cycles with walk=1 and ped_pending=0 from WALK entry, then MG.
REQ-041 PED_EN, ped_req and side_req together -> AR1 goes to WALK (3 cycles), then SG.
REQ-042 rst pulse in SG at timer=2 -> next edge phase=0, main_g=1, timer=0, latches cleared; tick=0 for 10 cycles with a pending request -> phase unchanged.
